// File: rtl/fp_mul_pkg.sv
// Shared types for the floating-point multiplier: FSM states and flag bit positions.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MULTIPLY  = 3'd1,
    NORMALIZE = 3'd2,
    ROUND     = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int unsigned FLAG_W         = 4;
  localparam int unsigned FLAG_INEXACT   = 0;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_INVALID   = 3;

endpackage

// File: rtl/fp_round_rne.sv
// Rounds a normalised significand, renormalises on carry-out and applies overflow/underflow.
// Round-to-nearest-even when FP_MUL_ROUND_EN is defined, truncation otherwise.
module fp_round_rne
  import fp_mul_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                       i_sign,
  input  logic signed [EXP_W+1:0]    i_exp,
  input  logic [MAN_W-1:0]           i_man,
  input  logic                       i_guard,
  input  logic                       i_round,
  input  logic                       i_sticky,
  output logic [EXP_W+MAN_W:0]       o_result_c,
  output logic [FLAG_W-1:0]          o_flags_c
);

  localparam int unsigned ES      = EXP_W + 2;
  localparam int unsigned EXP_MAX = (2 ** EXP_W) - 1;

  logic                    w_up;
  logic                    w_inexact;
  logic [MAN_W:0]          w_sum;
  logic [MAN_W-1:0]        w_man;
  logic signed [ES-1:0]    w_exp_adj;

`ifdef FP_MUL_ROUND_EN
  assign w_up = i_guard & (i_round | i_sticky | i_man[0]);
`else
  assign w_up = 1'b0;
`endif

  assign w_inexact = i_guard | i_round | i_sticky;
  assign w_sum     = {1'b0, i_man} + (MAN_W+1)'(w_up);
  // Carry out of the mantissa means 1.111..+ulp = 10.000..: bump exponent, mantissa wraps to zero.
  assign w_man     = w_sum[MAN_W] ? '0 : w_sum[MAN_W-1:0];
  assign w_exp_adj = i_exp + $signed({{(ES-1){1'b0}}, w_sum[MAN_W]});

  always_comb begin
    o_result_c = {i_sign, w_exp_adj[EXP_W-1:0], w_man};
    o_flags_c  = '0;
    o_flags_c[FLAG_INEXACT] = w_inexact;
    if (w_exp_adj >= $signed(ES'(EXP_MAX))) begin
      o_result_c = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_flags_c[FLAG_OVERFLOW] = 1'b1;
      o_flags_c[FLAG_INEXACT]  = 1'b1;
    end else if (w_exp_adj <= $signed(ES'(0))) begin
      o_result_c = {i_sign, {(EXP_W+MAN_W){1'b0}}};
      o_flags_c[FLAG_UNDERFLOW] = 1'b1;
      o_flags_c[FLAG_INEXACT]   = 1'b1;
    end
  end

endmodule

// File: rtl/fp_multiply_unit.sv
// Multi-cycle IEEE-style multiplier: IDLE->MULTIPLY->NORMALIZE->ROUND->DONE with valid/ready handshakes.
// Define FP_MUL_ROUND_EN for round-to-nearest-even; default build truncates.
module fp_multiply_unit
  import fp_mul_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [EXP_W+MAN_W:0]     a_i,
  input  logic [EXP_W+MAN_W:0]     b_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [EXP_W+MAN_W:0]     product_o,
  output logic [FLAG_W-1:0]        flags_o
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned SW   = MAN_W + 1;
  localparam int unsigned PW   = 2 * SW;
  localparam int unsigned ES   = EXP_W + 2;
  localparam int unsigned BIAS = (2 ** (EXP_W - 1)) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t                r_state, w_next_state;
  logic [W-1:0]          r_a, r_b;
  logic [PW-1:0]         r_prod;
  logic                  r_sign;
  logic signed [ES-1:0]  r_exp;
  logic                  r_spec;
  logic [W-1:0]          r_spec_res;
  logic [FLAG_W-1:0]     r_spec_flags;
  logic [MAN_W-1:0]      r_man;
  logic                  r_guard, r_round, r_sticky;
  logic [W-1:0]          r_product;
  logic [FLAG_W-1:0]     r_flags;
  logic                  r_valid, r_ready;

  logic [EXP_W-1:0]      w_ea, w_eb;
  logic [MAN_W-1:0]      w_ma, w_mb;
  logic                  w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic                  w_sign;
  logic [PW-1:0]         w_prod;
  logic signed [ES-1:0]  w_exp_sum;
  logic                  w_spec;
  logic [W-1:0]          w_spec_res;
  logic [FLAG_W-1:0]     w_spec_flags;
  logic                  w_msb;
  logic [MAN_W-1:0]      w_norm_man;
  logic                  w_norm_g, w_norm_r, w_norm_s;
  logic [W-1:0]          w_rnd_res;
  logic [FLAG_W-1:0]     w_rnd_flags;

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (valid_i) w_next_state = MULTIPLY;
      MULTIPLY:  w_next_state = NORMALIZE;
      NORMALIZE: w_next_state = ROUND;
      ROUND:     w_next_state = DONE;
      DONE:      if (ready_i) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_valid <= (w_next_state == DONE);
      r_ready <= (w_next_state == IDLE);
    end
  end

  // Operand decode; exp==0 is treated as zero regardless of mantissa
  assign w_ea     = r_a[W-2 -: EXP_W];
  assign w_eb     = r_b[W-2 -: EXP_W];
  assign w_ma     = r_a[MAN_W-1:0];
  assign w_mb     = r_b[MAN_W-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == '1) && (w_ma == '0);
  assign w_b_inf  = (w_eb == '1) && (w_mb == '0);
  assign w_a_nan  = (w_ea == '1) && (w_ma != '0);
  assign w_b_nan  = (w_eb == '1) && (w_mb != '0);
  assign w_sign   = r_a[W-1] ^ r_b[W-1];

  assign w_prod    = PW'({1'b1, w_ma}) * PW'({1'b1, w_mb});
  assign w_exp_sum = $signed(ES'(w_ea)) + $signed(ES'(w_eb)) - $signed(ES'(BIAS));

  always_comb begin
    w_spec       = 1'b1;
    w_spec_res   = '0;
    w_spec_flags = '0;
    if (w_a_nan || w_b_nan) begin
      w_spec_res = QNAN;
    end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_spec_res = QNAN;
      w_spec_flags[FLAG_INVALID] = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_a_zero || w_b_zero) begin
      w_spec_res = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_spec = 1'b0;
    end
  end

  // Product in [1,4): when the top bit is set, the window moves up one bit (right shift by one)
  assign w_msb = r_prod[PW-1];
  always_comb begin
    w_norm_man = r_prod[PW-3 -: MAN_W];
    w_norm_g   = r_prod[MAN_W-1];
    w_norm_r   = r_prod[MAN_W-2];
    w_norm_s   = |r_prod[MAN_W-3:0];
    if (w_msb) begin
      w_norm_man = r_prod[PW-2 -: MAN_W];
      w_norm_g   = r_prod[MAN_W];
      w_norm_r   = r_prod[MAN_W-1];
      w_norm_s   = |r_prod[MAN_W-2:0];
    end
  end

  fp_round_rne #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .i_sign     (r_sign),
    .i_exp      (r_exp),
    .i_man      (r_man),
    .i_guard    (r_guard),
    .i_round    (r_round),
    .i_sticky   (r_sticky),
    .o_result_c (w_rnd_res),
    .o_flags_c  (w_rnd_flags)
  );

  // Datapath registers, advanced by the current state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_a          <= '0;
      r_b          <= '0;
      r_prod       <= '0;
      r_sign       <= 1'b0;
      r_exp        <= '0;
      r_spec       <= 1'b0;
      r_spec_res   <= '0;
      r_spec_flags <= '0;
      r_man        <= '0;
      r_guard      <= 1'b0;
      r_round      <= 1'b0;
      r_sticky     <= 1'b0;
      r_product    <= '0;
      r_flags      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_a <= a_i;
            r_b <= b_i;
          end
        end
        MULTIPLY: begin
          r_prod       <= w_prod;
          r_sign       <= w_sign;
          r_exp        <= w_exp_sum;
          r_spec       <= w_spec;
          r_spec_res   <= w_spec_res;
          r_spec_flags <= w_spec_flags;
        end
        NORMALIZE: begin
          r_man    <= w_norm_man;
          r_guard  <= w_norm_g;
          r_round  <= w_norm_r;
          r_sticky <= w_norm_s;
          r_exp    <= r_exp + $signed({{(ES-1){1'b0}}, w_msb});
        end
        ROUND: begin
          r_product <= r_spec ? r_spec_res   : w_rnd_res;
          r_flags   <= r_spec ? r_spec_flags : w_rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign ready_o   = r_ready;
  assign valid_o   = r_valid;
  assign product_o = r_product;
  assign flags_o   = r_flags;

endmodule

// File: tb/tb_fp_multiply_unit.sv
// Bench for fp_multiply_unit (FP32): directed corner cases plus random operands vs an arithmetic model.
module tb_fp_multiply_unit;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] product_o;
  logic [3:0]  flags_o;

  int n_cmp = 0;
  int n_err = 0;

  fp_multiply_unit #(.EXP_W(8), .MAN_W(23)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .product_o (product_o),
    .flags_o   (flags_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value-level model: integer significand product, remainder-vs-half rounding.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [3:0] fl);
    int e, ea, eb, sh;
    logic s;
    longint unsigned ma, mb, p, q, rem;
`ifdef FP_MUL_ROUND_EN
    longint unsigned half;
`endif
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ma = 64'(a[22:0]);   mb = 64'(b[22:0]);
    s  = a[31] ^ b[31];
    a_zero = (ea == 0); b_zero = (eb == 0);
    a_inf  = (ea == 255) && (ma == 0); b_inf = (eb == 255) && (mb == 0);
    a_nan  = (ea == 255) && (ma != 0); b_nan = (eb == 255) && (mb != 0);
    fl = 4'b0000;
    if (a_nan || b_nan) begin
      res = 32'h7FC0_0000;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      res = 32'h7FC0_0000; fl = 4'b1000;
    end else if (a_inf || b_inf) begin
      res = {s, 31'h7F80_0000};
    end else if (a_zero || b_zero) begin
      res = {s, 31'h0};
    end else begin
      p = ((64'd1 << 23) + ma) * ((64'd1 << 23) + mb);
      e = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
      else sh = 23;
      q   = p >> sh;
      rem = p - (q << sh);
`ifdef FP_MUL_ROUND_EN
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
      if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e = e + 1; end
      if (e >= 255) begin
        res = {s, 31'h7F80_0000}; fl = 4'b0101;
      end else if (e <= 0) begin
        res = {s, 31'h0}; fl = 4'b0011;
      end else begin
        res = {s, 8'(e), q[22:0]};
        fl  = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    m = 23'($urandom);
    case ($urandom_range(0, 11))
      0:       e = 8'd0;
      1:       begin e = 8'd255; m = '0; end
      2:       begin e = 8'd255; m = m | 23'd1; end
      3:       e = 8'($urandom_range(190, 254));
      4:       e = 8'($urandom_range(1, 64));
      5:       begin e = 8'($urandom_range(100, 150)); m = m & 23'h7F_0001; end
      default: e = 8'($urandom_range(80, 175));
    endcase
    return {1'($urandom), e, m};
  endfunction

  // Issues one operation, checks latency/result against the model, then stalls `hold` cycles in DONE.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                       output logic [31:0] res, output logic [3:0] fl);
    int k;
    logic [31:0] er, held;
    logic [3:0]  ef;
    @(negedge clk_i);
    check_eq("ready_idle", 32'(ready_o), 32'd1);
    valid_i = 1'b1; a_i = a; b_i = b;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0; a_i = $urandom; b_i = $urandom;
    k = 0;
    while (!valid_o && k < 12) begin
      @(posedge clk_i);
      @(negedge clk_i);
      k++;
      valid_i = 1'($urandom);
      a_i = $urandom; b_i = $urandom;
    end
    valid_i = 1'b0;
    check_eq("latency", 32'(k), 32'd3);
    ref_mul(a, b, er, ef);
    res = product_o; fl = flags_o;
    check_eq("product", product_o, er);
    check_eq("flags", 32'(flags_o), 32'(ef));
    held = product_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'($urandom); a_i = $urandom; b_i = $urandom;
      check_eq("hold_valid", 32'(valid_o), 32'd1);
      check_eq("hold_ready", 32'(ready_o), 32'd0);
      check_eq("hold_product", product_o, held);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    ready_i = 1'b0;
    check_eq("release_valid", 32'(valid_o), 32'd0);
    check_eq("release_ready", 32'(ready_o), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    int          seen;

    repeat (2) @(negedge clk_i);
    check_eq("rst_product", product_o, 32'd0);
    check_eq("rst_flags", 32'(flags_o), 32'd0);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_ready", 32'(ready_o), 32'd1);
    reset_i = 1'b0;

    do_op(32'h4000_0000, 32'h4040_0000, 0, r, f);
    check_eq("d_2x3", r, 32'h40C0_0000);
    check_eq("d_2x3_fl", 32'(f), 32'd0);

    do_op(32'h3F80_0001, 32'h3FC0_0000, 0, r, f);
`ifdef FP_MUL_ROUND_EN
    check_eq("d_tie", r, 32'h3FC0_0002);
`else
    check_eq("d_tie", r, 32'h3FC0_0001);
`endif
    check_eq("d_tie_inexact", 32'(f[0]), 32'd1);

    do_op(32'h7F80_0000, 32'h0000_0000, 0, r, f);
    check_eq("d_infx0", r, 32'h7FC0_0000);
    check_eq("d_infx0_fl", 32'(f), 32'h8);

    do_op(32'h7F00_0000, 32'h7F00_0000, 5, r, f);
    check_eq("d_ovf", r, 32'h7F80_0000);
    check_eq("d_ovf_fl", 32'(f), 32'h5);

    do_op(32'h0080_0000, 32'h0080_0000, 0, r, f);
    check_eq("d_unf", r, 32'h0000_0000);
    check_eq("d_unf_fl", 32'(f), 32'h3);

    // Reset while the operation sits in NORMALIZE
    do_op(32'h4000_0000, 32'h4040_0000, 0, r, f);
    @(negedge clk_i);
    valid_i = 1'b1; a_i = 32'h3FC0_0000; b_i = 32'h4000_0000;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    check_eq("mid_rst_product", product_o, 32'd0);
    check_eq("mid_rst_flags", 32'(flags_o), 32'd0);
    check_eq("mid_rst_valid", 32'(valid_o), 32'd0);
    check_eq("mid_rst_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    reset_i = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    check_eq("mid_rst_no_result", 32'(seen), 32'd0);
    do_op(32'hC0A0_0000, 32'h3F00_0000, 1, r, f);
    check_eq("post_rst", r, 32'hC020_0000);

    for (int n = 0; n < 300; n++) begin
      do_op(rand_fp(), rand_fp(), $urandom_range(0, 2), r, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_multiply_unit.md
FP_MULTIPLY_UNIT -- requirements
Module: fp_multiply_unit

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port valid_i  input  1  operands valid.
REQ-006 SHALL have port ready_o  output  1  unit accepts operands.
REQ-007 SHALL have port a_i  input  W  operand A, IEEE-style {sign,exp,man}.
REQ-008 SHALL have port b_i  input  W  operand B, same format.
REQ-009 SHALL have port valid_o  output  1  product_o/flags_o valid.
REQ-010 SHALL have port ready_i  input  1  consumer accepts result.
REQ-011 SHALL have port product_o  output  W  registered product.
REQ-012 SHALL have port flags_o  output  4  {invalid, overflow, underflow, inexact}, registered.

Function
REQ-013 SHALL sequence states IDLE->MULTIPLY->NORMALIZE->ROUND->DONE->IDLE, one state per cycle except IDLE and DONE.
REQ-014 SHALL drive ready_o=1 only in IDLE; SHALL capture a_i/b_i on the edge where valid_i&&ready_o, moving to MULTIPLY.
REQ-015 SHALL assert valid_o only in DONE, reached on the 3rd rising edge after the accepting edge.
REQ-016 SHALL hold valid_o, product_o, flags_o stable in DONE until valid_o&&ready_i, then return to IDLE on that edge.
REQ-017 SHALL ignore valid_i and a_i/b_i changes outside IDLE.
REQ-018 SHALL compute the (MAN_W+1)x(MAN_W+1) significand product with hidden bit 1, 2*(MAN_W+1) bits wide, in MULTIPLY.
REQ-019 SHALL normalise in NORMALIZE: if product MSB set, shift right one and increment exponent; exponent math in signed EXP_W+2 bits as ea+eb-bias(+1), bias = 2^(EXP_W-1)-1.
REQ-020 SHALL set result sign = sign_a XOR sign_b for all non-NaN results.
REQ-021 SHALL treat exp=0 operands as zero (subnormals flushed); zero x finite -> signed zero, no flags.
REQ-022 SHALL output canonical qNaN (sign 0, exp all ones, man MSB 1, rest 0) for any NaN operand or inf x zero; invalid set only for inf x zero.
REQ-023 SHALL output signed infinity for inf x nonzero finite or inf, no flags.
REQ-024 SHALL, after rounding, output signed infinity with overflow set when biased exponent >= 2^EXP_W-1.
REQ-025 SHALL output signed zero with underflow set when biased exponent <= 0.
REQ-026 SHALL set inexact when any discarded product bit is nonzero (also asserted with overflow/underflow).
REQ-027 SHALL renormalise when rounding carries out of the mantissa (exponent +1, mantissa 0), rechecking overflow.

Reset
REQ-028 SHALL on reset_i assertion, at any time including mid-operation, immediately force state IDLE, product_o=0, flags_o=0, valid_o=0; ready_o=1 once in IDLE.
REQ-029 SHALL discard any in-flight operation on reset; no result is produced for it.

Configuration
REQ-030 SHALL, with FP_MUL_ROUND_EN defined, round to nearest, ties to even, using guard/round/sticky in ROUND.
REQ-031 SHALL, without FP_MUL_ROUND_EN, truncate; ROUND state still occupies one cycle, latency unchanged, inexact still reported.

Structure
REQ-032 SHALL place state_t enum (IDLE, MULTIPLY, NORMALIZE, ROUND, DONE) and flag bit index constants in package fp_mul_pkg.
REQ-033 SHALL implement rounding/renormalisation in sub-module fp_round_rne, instantiated once.

Verification (FP32 defaults)
REQ-034 SHALL check 0x40000000 x 0x40400000 -> 0x40C00000, flags 0, valid_o 3 edges after accept.
REQ-035 SHALL check 0x3F800001 x 0x3FC00000 -> 0x3FC00002 with macro, 0x3FC00001 without; inexact=1 both.
REQ-036 SHALL check 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1; 0x7F000000 x 0x7F000000 -> 0x7F800000, overflow=1, inexact=1.
REQ-037 SHALL check ready_i held low 5 cycles in DONE: valid_o=1, product_o stable, ready_o=0, valid_i pulses ignored.
REQ-038 SHALL check reset_i pulsed during NORMALIZE: outputs zero immediately, ready_o=1 after, next operation correct.
